// File: rtl/cpu_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_control_unit                                           |
// | Description : Program counter and instruction decoder driving the 8-bit  |
// |               ALU and register file. Resolves branches from the ALU      |
// |               ZERO flag, stretches MULT over two cycles and stalls on    |
// |               instruction-memory BUSYWAIT.                               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module cpu_control_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         INSTRUCTION,
  input  logic                ZERO,
  input  logic                BUSYWAIT,
  output logic [PC_WIDTH-1:0] PC,
  output logic [2:0]          ALUOP,
  output logic                IMMSELECT,
  output logic                NEGSELECT,
  output logic                WRITEENABLE,
  output logic [2:0]          WRITEREG,
  output logic [2:0]          READREG1,
  output logic [2:0]          READREG2,
  output logic [7:0]          IMMEDIATE
);

  typedef enum logic [0:0] {
    EXEC    = 1'b0,
    MULWAIT = 1'b1
  } state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_MULT  = 8'h08;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  state_t                state;
  state_t                next_state;
  logic [PC_WIDTH-1:0]   next_pc;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic [PC_WIDTH-1:0]   offset_ext;
  logic [PC_WIDTH-1:0]   branch_target;
  logic                  decode_we;
  logic [7:0]            opcode;
  logic                  unused_src1_hi;

  assign opcode    = INSTRUCTION[31:24];
  assign WRITEREG  = INSTRUCTION[18:16];
  assign READREG1  = INSTRUCTION[10:8];
  assign READREG2  = INSTRUCTION[2:0];
  assign IMMEDIATE = INSTRUCTION[7:0];

  // Upper src1 bits carry no meaning for an 8-register file.
  assign unused_src1_hi = ^INSTRUCTION[15:11];

  // Word offset is sign-extended and scaled to bytes; wrap is modulo 2^PC_WIDTH.
  assign offset_ext    = {{(PC_WIDTH-10){INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
  assign pc_plus4      = PC + PC_WIDTH'(4);
  assign branch_target = pc_plus4 + offset_ext;

  // Register-file write is suppressed during a memory stall and during reset.
  assign WRITEENABLE = decode_we & ~BUSYWAIT & ~RESET;

  // State and program counter register; reset beats BUSYWAIT and aborts MULT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= EXEC;
      PC    <= RESET_PC;
    end else begin
      state <= next_state;
      PC    <= next_pc;
    end
  end

  // Instruction decode plus next-state / next-PC selection.
  always_comb begin
    next_state = state;
    next_pc    = PC;
    ALUOP      = ALU_FWD;
    IMMSELECT  = 1'b0;
    NEGSELECT  = 1'b0;
    decode_we  = 1'b0;

    case (opcode)
      OP_LOADI: begin ALUOP = ALU_FWD; IMMSELECT = 1'b1; decode_we = 1'b1; end
      OP_MOV:   begin ALUOP = ALU_FWD; decode_we = 1'b1; end
      OP_ADD:   begin ALUOP = ALU_ADD; decode_we = 1'b1; end
      OP_SUB:   begin ALUOP = ALU_ADD; NEGSELECT = 1'b1; decode_we = 1'b1; end
      OP_AND:   begin ALUOP = ALU_AND; decode_we = 1'b1; end
      OP_OR:    begin ALUOP = ALU_OR;  decode_we = 1'b1; end
      OP_J:     begin ALUOP = ALU_FWD; end
      OP_BEQ:   begin ALUOP = ALU_ADD; NEGSELECT = 1'b1; end
      OP_MULT:  begin ALUOP = ALU_MUL; end
      default:  begin ALUOP = ALU_FWD; end
    endcase

    if (state == MULWAIT) begin
      // Second MULT cycle: product has settled, commit it and move on.
      ALUOP     = ALU_MUL;
      decode_we = 1'b1;
      if (!BUSYWAIT) begin
        next_state = EXEC;
        next_pc    = pc_plus4;
      end
    end else if (!BUSYWAIT) begin
      case (opcode)
        OP_MULT: next_state = MULWAIT;
        OP_J:    next_pc    = branch_target;
        OP_BEQ:  next_pc    = ZERO ? branch_target : pc_plus4;
        default: next_pc    = pc_plus4;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cpu_control_unit                                        |
// | Description : Scoreboard bench: driver pushes expected outputs from a    |
// |               behavioural program model, monitor pops and compares.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_cpu_control_unit;

  logic        clk;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic        BUSYWAIT;
  logic [31:0] PC;
  logic [2:0]  ALUOP;
  logic        IMMSELECT;
  logic        NEGSELECT;
  logic        WRITEENABLE;
  logic [2:0]  WRITEREG;
  logic [2:0]  READREG1;
  logic [2:0]  READREG2;
  logic [7:0]  IMMEDIATE;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  aluop;
    logic        imm;
    logic        neg;
    logic        we;
    logic [2:0]  wr;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [7:0]  immv;
  } exp_t;

  exp_t q[$];

  // Reference model: program counter and "second half of a multiply pending".
  logic [31:0] m_pc;
  bit          m_mul_second;

  cpu_control_unit #(.PC_WIDTH(32), .RESET_PC(32'd0)) dut (
    .CLK(clk), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
    .BUSYWAIT(BUSYWAIT), .PC(PC), .ALUOP(ALUOP), .IMMSELECT(IMMSELECT),
    .NEGSELECT(NEGSELECT), .WRITEENABLE(WRITEENABLE), .WRITEREG(WRITEREG),
    .READREG1(READREG1), .READREG2(READREG2), .IMMEDIATE(IMMEDIATE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU select expected for each opcode in a normal execute cycle.
  function automatic logic [2:0] alu_of(input logic [7:0] op);
    case (op)
      8'h02, 8'h03, 8'h07: return 3'd1;
      8'h04:               return 3'd2;
      8'h05:               return 3'd3;
      8'h08:               return 3'd4;
      default:             return 3'd0;
    endcase
  endfunction

  // One clock cycle: apply inputs, record the expected outputs, advance the model.
  task automatic step(input logic [31:0] ins, input logic z, input logic b, input logic r);
    exp_t        e;
    logic [7:0]  op;
    logic [31:0] target;
    @(negedge clk);
    INSTRUCTION = ins; ZERO = z; BUSYWAIT = b; RESET = r;
    #1;
    op      = ins[31:24];
    e.pc    = m_pc;
    e.aluop = m_mul_second ? 3'd4 : alu_of(op);
    e.imm   = (op == 8'h00);
    e.neg   = (op == 8'h03) || (op == 8'h07);
    e.we    = !r && !b && (m_mul_second || (op <= 8'h05));
    e.wr    = ins[18:16];
    e.r1    = ins[10:8];
    e.r2    = ins[2:0];
    e.immv  = ins[7:0];
    q.push_back(e);

    target = m_pc + 32'd4 + (32'(signed'(ins[23:16])) * 32'd4);
    if (r) begin
      m_pc = 32'd0; m_mul_second = 0;
    end else if (b) begin
      // stall: nothing moves
    end else if (m_mul_second) begin
      m_pc = m_pc + 32'd4; m_mul_second = 0;
    end else begin
      case (op)
        8'h08:   m_mul_second = 1;
        8'h06:   m_pc = target;
        8'h07:   m_pc = z ? target : m_pc + 32'd4;
        default: m_pc = m_pc + 32'd4;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so one result is presented every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("pc",        PC,          e.pc);
        check("aluop",     {29'd0, ALUOP},     {29'd0, e.aluop});
        check("immselect", {31'd0, IMMSELECT}, {31'd0, e.imm});
        check("negselect", {31'd0, NEGSELECT}, {31'd0, e.neg});
        check("writeen",   {31'd0, WRITEENABLE}, {31'd0, e.we});
        check("writereg",  {29'd0, WRITEREG},  {29'd0, e.wr});
        check("readreg1",  {29'd0, READREG1},  {29'd0, e.r1});
        check("readreg2",  {29'd0, READREG2},  {29'd0, e.r2});
        check("immediate", {24'd0, IMMEDIATE}, {24'd0, e.immv});
      end
    end
  end

  // Driver: directed program walk followed by randomized traffic.
  initial begin
    logic [31:0] ins;
    logic [7:0]  op;
    int          sel;
    RESET = 1'b1; INSTRUCTION = 32'h0; ZERO = 1'b0; BUSYWAIT = 1'b0;
    m_pc = 32'd0; m_mul_second = 0;
    @(posedge clk);

    step(32'h0002_0005, 0, 0, 1);
    step(32'h0002_0005, 0, 0, 1);
    step(32'h0002_0005, 0, 0, 0);   // loadi r2,5 @0  -> 4
    step(32'h0501_0203, 0, 0, 0);   // or @4          -> 8
    step(32'h0303_0102, 0, 0, 0);   // sub r3,r1,r2 @8 -> 12
    step(32'h0205_0102, 0, 1, 0);   // add @12 stalled x3
    step(32'h0205_0102, 0, 1, 0);
    step(32'h0205_0102, 0, 1, 0);
    step(32'h0205_0102, 0, 0, 0);   // add commits    -> 16
    step(32'h0702_0102, 1, 0, 0);   // beq +2 taken   -> 28
    step(32'h06FC_0000, 0, 0, 0);   // j -4 @28       -> 16
    step(32'h0702_0102, 0, 0, 0);   // beq not taken  -> 20
    step(32'h0604_0000, 0, 0, 0);   // j +4 @20       -> 40
    step(32'h06FE_0000, 0, 0, 0);   // j -2 @40       -> 36
    step(32'h06FF_0000, 0, 0, 0);   // j -1 @36 self-loop
    step(32'h0000_0000, 0, 0, 1);   // reset          -> 0
    step(32'h0804_0102, 0, 0, 0);   // mult cycle 1
    step(32'h0804_0102, 0, 0, 0);   // mult cycle 2   -> 4
    step(32'h0804_0102, 0, 0, 0);   // mult @4 cycle 1
    step(32'h0804_0102, 0, 0, 1);   // reset in MULWAIT -> 0
    step(32'h0201_0203, 0, 0, 0);   // add @0         -> 4
    step(32'hFF01_0203, 0, 0, 0);   // nop @4         -> 8
    step(32'h0000_0000, 0, 0, 0);

    ins = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!(m_mul_second && ($urandom_range(0, 9) < 8))) begin
        sel = int'($urandom_range(0, 10));
        if (sel <= 8)       op = 8'(sel);
        else if (sel == 9)  op = 8'hFF;
        else                op = 8'($urandom_range(9, 254));
        ins = {op, 24'($urandom)};
      end
      step(ins, 1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0));
    end

    repeat (2) @(negedge clk);
    #3;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Instruction-side counterpart to the 8-bit ALU. Holds the program counter and decodes each 32-bit instruction.
- Drives ALU SELECT, operand-mux controls and register-file addresses and write enable.
- Consumes the ALU zero/compare flag to resolve branches.
- Sequences a two-cycle MULT so the multiplier path settles before write-back. Stalls on memory BUSYWAIT.

Parameters:
- PC_WIDTH, 32, program counter width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous active-high reset.
- INSTRUCTION  input  32  instruction at current PC: [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/immediate.
- ZERO  input  1  ALU compare flag; 1 when ALU RESULT == 0.
- BUSYWAIT  input  1  instruction memory not ready; freezes the unit.
- PC  output  PC_WIDTH  current program counter.
- ALUOP  output  3  ALU SELECT: 000 fwd, 001 add, 010 and, 011 or, 100 mul.
- IMMSELECT  output  1  1 = ALU DATA2 takes IMMEDIATE.
- NEGSELECT  output  1  1 = ALU DATA2 is two's-complement of src2.
- WRITEENABLE  output  1  register-file write strobe for this cycle.
- WRITEREG  output  3  destination register, INSTRUCTION[18:16].
- READREG1  output  3  INSTRUCTION[10:8].
- READREG2  output  3  INSTRUCTION[2:0].
- IMMEDIATE  output  8  INSTRUCTION[7:0].

Behaviour:
- Reset: at a rising CLK with RESET=1, PC<=RESET_PC and state<=EXEC. RESET has priority over BUSYWAIT and over any in-flight MULT. Reset mid-MULT aborts the MULT with no write.
- While RESET=1, WRITEENABLE=0.
- Decode is combinational from INSTRUCTION and state:
  - 0x00 loadi: ALUOP 000, IMMSELECT 1, write.
  - 0x01 mov: ALUOP 000, write.
  - 0x02 add: ALUOP 001, write.
  - 0x03 sub: ALUOP 001, NEGSELECT 1, write.
  - 0x04 and: ALUOP 010, write.
  - 0x05 or: ALUOP 011, write.
  - 0x06 j: no write.
  - 0x07 beq: ALUOP 001, NEGSELECT 1, no write.
  - 0x08 mult: ALUOP 100, write in the second cycle only.
  - Any other opcode: ALUOP 000, no write; treated as NOP.
- Default values: IMMSELECT=0, NEGSELECT=0, WRITEENABLE=0 unless stated above.
- FSM states EXEC and MULWAIT:
  - EXEC with opcode 0x08 and no BUSYWAIT: go to MULWAIT. PC holds. WRITEENABLE=0.
  - MULWAIT: ALUOP stays 100 and WRITEENABLE=1. Next edge goes to EXEC and PC<=PC+4.
- Next PC in EXEC, latency 1 cycle:
  - Default: PC+4.
  - j: PC+4+({{22{off[7]}},off,2'b00}), where off=INSTRUCTION[23:16].
  - beq: same target if ZERO=1, else PC+4.
- PC arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- BUSYWAIT=1 at an edge: PC and state hold, and WRITEENABLE is forced to 0 in that cycle. Decode outputs other than WRITEENABLE still follow INSTRUCTION.
- ZERO is sampled only at the edge ending a beq EXEC cycle.
- Negative offset 0xFF on j gives a target of PC, i.e. a self-loop.

Test Plan:
- RESET=1 for 2 edges with PC running -> PC=0, WRITEENABLE=0. After release, INSTRUCTION=0x0002_0005 (loadi r2,5) -> IMMSELECT=1, ALUOP=000, WRITEREG=2, WRITEENABLE=1, PC=4 next edge.
- At PC=8, INSTRUCTION=0x0303_0102 (sub r3,r1,r2) -> ALUOP=001, NEGSELECT=1, READREG1=1, READREG2=2, PC=12.
- At PC=16, beq offset 0x02: ZERO=1 -> PC=28; repeat with ZERO=0 -> PC=20. At PC=40, j offset 0xFE -> PC=36.
- At PC=0, mult r4,r1,r2 -> cycle 1: ALUOP=100, WRITEENABLE=0, PC=0. Cycle 2: WRITEENABLE=1, WRITEREG=4. Then PC=4.
- BUSYWAIT=1 for 3 cycles during add at PC=12 -> PC stays 12, WRITEENABLE=0 throughout. After BUSYWAIT drops, one write and PC=16.
- RESET asserted in MULWAIT -> no write, PC=0, state EXEC. Opcode 0xFF at PC=4 -> no write, PC=8.
